// File: rtl/stackcalc_sel_pkg.sv
// Shared definitions for the stack operand sequencer.
//   SEL_SINGLE / SEL_UP / SEL_DOWN : req_mode encodings (2'b11 is treated as single)
//   sel_state_e                    : sequencer FSM states
package stackcalc_sel_pkg;

   localparam logic [1:0] SEL_SINGLE = 2'b00;
   localparam logic [1:0] SEL_UP     = 2'b01;
   localparam logic [1:0] SEL_DOWN   = 2'b10;

   typedef enum logic {
      IDLE,
      RUN
   } sel_state_e;

endpackage

// File: rtl/sel_mux_core.sv
// Combinational word selector: picks channel idx out of a flattened channel bus.
//   in_flat : NUM_CH*WIDTH  channel k = in_flat[k*WIDTH +: WIDTH]
//   idx     : SEL_W         channel index
//   word    : WIDTH         selected word, zero when idx >= NUM_CH
module sel_mux_core #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 16,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH*WIDTH-1:0] in_flat,
   input  logic [SEL_W-1:0]        idx,
   output logic [WIDTH-1:0]        word
);

   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (idx == SEL_W'(k)) word = in_flat[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/stack_operand_sequencer.sv
// Registered operand sequencer: serves single-word or burst requests over NUM_CH
// flattened channels on a valid/ready output stream.
//   clk, rst_n           : clock, async active-low reset
//   in_flat              : channel words, sampled when each beat loads
//   req_valid/req_ready  : request handshake; req_mode, req_sel, req_len sampled on accept
//   out_valid/out_ready  : beat handshake; out_data, out_idx, out_last
//   busy                 : high from acceptance until the last beat is consumed
module stack_operand_sequencer #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 16,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_flat,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_mode,
   input  logic [SEL_W-1:0]        req_sel,
   input  logic [SEL_W:0]          req_len,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    busy
);

   import stackcalc_sel_pkg::*;

   localparam int               LEN_W    = SEL_W + 1;
   localparam logic [LEN_W-1:0] NUM_CH_L = LEN_W'(NUM_CH);
   localparam logic [SEL_W-1:0] MAX_IDX  = SEL_W'(NUM_CH - 1);

   // Modulo step; out-of-range indices snap to the wrap target of the direction.
   function automatic logic [SEL_W-1:0] step_idx(input logic [SEL_W-1:0] idx,
                                                 input logic down);
      if (down) begin
         if (idx == '0 || {1'b0, idx} >= NUM_CH_L) return MAX_IDX;
         return idx - 1'b1;
      end
      if (idx >= MAX_IDX) return '0;
      return idx + 1'b1;
   endfunction

   sel_state_e       state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;      // next index to issue while in RUN
   logic [LEN_W-1:0] rem_q, rem_d;      // beats still to load while in RUN
   logic             dir_q, dir_d;      // 1 = descending
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             busy_q, busy_d;

   logic             load_ok, accept, load, load_last, consume_last;
   logic             req_is_burst, req_down;
   logic [LEN_W-1:0] req_beats;
   logic [SEL_W-1:0] load_idx;
   logic [WIDTH-1:0] load_word;

   sel_mux_core #(
      .WIDTH  (WIDTH),
      .NUM_CH (NUM_CH)
   ) u_mux (
      .in_flat (in_flat),
      .idx     (load_idx),
      .word    (load_word)
   );

   // Request decode and beat-load control.
   always_comb begin
      req_is_burst = (req_mode == SEL_UP) || (req_mode == SEL_DOWN);
      req_down     = (req_mode == SEL_DOWN);
      req_beats    = (req_len == '0 || req_len > NUM_CH_L) ? NUM_CH_L : req_len;
      load_ok      = ~out_valid_q | out_ready;
      accept       = req_valid & req_ready;
      load         = accept | ((state_q == RUN) & load_ok);
      load_idx     = (state_q == RUN) ? idx_q : req_sel;
      load_last    = (state_q == RUN) ? (rem_q == LEN_W'(1))
                                      : (~req_is_burst | (req_beats == LEN_W'(1)));
      consume_last = out_valid_q & out_ready & out_last_q;
   end

   // FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state. Leave RUN on the edge that loads the final beat.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && req_is_burst && req_beats != LEN_W'(1)) state_d = RUN;
         RUN:     if (load_ok && rem_q == LEN_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs.
   always_comb begin
      req_ready = (state_q == IDLE) & load_ok;
      out_valid = out_valid_q;
      out_data  = out_data_q;
      out_idx   = out_idx_q;
      out_last  = out_last_q;
      busy      = busy_q;
   end

   // Datapath next state: burst stepper, beat counter, output stage.
   always_comb begin
      idx_d       = idx_q;
      rem_d       = rem_q;
      dir_d       = dir_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = load_word;
         out_idx_d   = load_idx;
         out_last_d  = load_last;
         if (state_q == RUN) begin
            idx_d = step_idx(idx_q, dir_q);
            rem_d = rem_q - 1'b1;
         end else begin
            idx_d = step_idx(req_sel, req_down);
            rem_d = req_beats - 1'b1;
            dir_d = req_down;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // A request accepted on the consuming edge keeps busy high.
      busy_d = accept ? 1'b1 : (consume_last ? 1'b0 : busy_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         rem_q       <= '0;
         dir_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         dir_q       <= dir_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_stack_operand_sequencer.sv
// Bench: two sequencers (16 and 10 channels) driven by the same request stream,
// each checked every cycle against a queue-based beat model, plus literal checks.
module tb_stack_operand_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] in_flat = '0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_mode = '0;
   logic [3:0]  req_sel = '0;
   logic [4:0]  req_len = '0;
   logic        out_ready = 1'b1;

   logic       o_valid[2], o_last[2], o_busy[2], o_rr[2];
   logic [3:0] o_data[2], o_idx[2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   stack_operand_sequencer #(.WIDTH(4), .NUM_CH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_flat(in_flat),
      .req_valid(req_valid), .req_ready(o_rr[0]), .req_mode(req_mode),
      .req_sel(req_sel), .req_len(req_len),
      .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(o_data[0]),
      .out_idx(o_idx[0]), .out_last(o_last[0]), .busy(o_busy[0])
   );

   stack_operand_sequencer #(.WIDTH(4), .NUM_CH(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .in_flat(in_flat[39:0]),
      .req_valid(req_valid), .req_ready(o_rr[1]), .req_mode(req_mode),
      .req_sel(req_sel), .req_len(req_len),
      .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(o_data[1]),
      .out_idx(o_idx[1]), .out_last(o_last[1]), .busy(o_busy[1])
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- beat model ----------------
   int q16[$];
   int q10[$];
   bit m_valid[2];
   bit m_last[2];
   bit m_busy[2];
   int m_idx[2];
   int m_data[2];

   function automatic int nch(input int d);
      return (d == 0) ? 16 : 10;
   endfunction

   function automatic int word_of(input int d, input int idx);
      if (idx >= nch(d)) return 0;
      return int'(in_flat[idx*4 +: 4]);
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q16.size() : q10.size();
   endfunction

   function automatic bit m_ready(input int d);
      return (qsize(d) == 0) && (!m_valid[d] || out_ready);
   endfunction

   task automatic present(input int d);
      int idx;
      if (d == 0) idx = q16.pop_front();
      else        idx = q10.pop_front();
      m_valid[d] = 1'b1;
      m_idx[d]   = idx;
      m_data[d]  = word_of(d, idx);
      m_last[d]  = (qsize(d) == 0);
   endtask

   task automatic model_reset();
      q16.delete();
      q10.delete();
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 0; m_last[d] = 0; m_busy[d] = 0; m_idx[d] = 0; m_data[d] = 0;
      end
   endtask

   // One request expands into its full list of channel indices.
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit lok, cons_last, acc;
         int n, cur;
         int lst[$];
         n         = nch(d);
         lok       = !m_valid[d] || out_ready;
         cons_last = m_valid[d] && out_ready && m_last[d];
         acc       = 0;
         if (lok) begin
            if (qsize(d) > 0) begin
               present(d);
            end else if (req_valid) begin
               int beats;
               acc = 1;
               if (req_mode == 2'b01 || req_mode == 2'b10)
                  beats = (req_len == 0 || int'(req_len) > n) ? n : int'(req_len);
               else
                  beats = 1;
               cur = int'(req_sel);
               for (int b = 0; b < beats; b++) begin
                  lst.push_back(cur);
                  if (cur >= n)              cur = (req_mode == 2'b01) ? 0 : n - 1;
                  else if (req_mode == 2'b01) cur = (cur + 1) % n;
                  else                        cur = (cur + n - 1) % n;
               end
               if (d == 0) q16 = lst;
               else        q10 = lst;
               present(d);
            end else begin
               m_valid[d] = 1'b0;
            end
         end
         if (acc)            m_busy[d] = 1'b1;
         else if (cons_last) m_busy[d] = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Per-cycle comparison, half a period away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d out_valid", d), int'(o_valid[d]), int'(m_valid[d]));
            chk($sformatf("d%0d busy", d), int'(o_busy[d]), int'(m_busy[d]));
            chk($sformatf("d%0d req_ready", d), int'(o_rr[d]), int'(m_ready(d)));
            if (m_valid[d]) begin
               chk($sformatf("d%0d out_data", d), int'(o_data[d]), m_data[d]);
               chk($sformatf("d%0d out_idx", d), int'(o_idx[d]), m_idx[d]);
               chk($sformatf("d%0d out_last", d), int'(o_last[d]), int'(m_last[d]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns one time unit after the accepting edge.
   task automatic send(input logic [1:0] mode, input logic [3:0] sel, input logic [4:0] len);
      int cnt;
      req_valid = 1'b1;
      req_mode  = mode;
      req_sel   = sel;
      req_len   = len;
      cnt = 0;
      while (!o_rr[0] && cnt < 50) begin
         tick();
         cnt++;
      end
      if (cnt == 50) chk("send ready timeout", 0, 1);
      tick();
      req_valid = 1'b0;
      req_mode  = $urandom_range(0, 3);
      req_sel   = $urandom_range(0, 15);
      req_len   = $urandom_range(0, 31);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] hold_d;
      logic [3:0] hold_i;
      int cnt[2];
      bit done[2];
      int exp_up[4];
      exp_up = '{14, 15, 0, 1};

      // 1: reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_flat   = {$urandom, $urandom};
         req_valid = 1'($urandom);
         req_mode  = 2'($urandom);
         req_sel   = 4'($urandom);
         req_len   = 5'($urandom);
         out_ready = 1'($urandom);
         tick();
         chk("rst out_valid", int'(o_valid[0]), 0);
         chk("rst out_data", int'(o_data[0]), 0);
         chk("rst busy", int'(o_busy[1]), 0);
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      in_flat   = 64'h3C2B_1A09_F8E7_D6C5;
      rst_n     = 1'b1;
      tick();
      chk("post-rst req_ready", int'(o_rr[0]), 1);

      // 2: single on channel 5
      in_flat[23:20] = 4'hA;
      send(2'b00, 4'd5, 5'd0);
      chk("single data", int'(o_data[0]), 4'hA);
      chk("single idx", int'(o_idx[0]), 5);
      chk("single last", int'(o_last[0]), 1);
      chk("single req_ready", int'(o_rr[0]), 1);
      chk("single data n10", int'(o_data[1]), 4'hA);

      // 3: burst up 14,15,0,1; ch15 rewritten after acceptance
      in_flat[63:60] = 4'h1;
      send(2'b01, 4'd14, 5'd4);
      for (int i = 0; i < 4; i++) begin
         chk("up idx", int'(o_idx[0]), exp_up[i]);
         chk("up last", int'(o_last[0]), (i == 3) ? 1 : 0);
         if (i == 0) in_flat[63:60] = 4'h7;
         if (i == 1) chk("up late data", int'(o_data[0]), 4'h7);
         tick();
      end

      // 4: burst down 1,0,15 with two stall cycles on beat 2
      send(2'b10, 4'd1, 5'd3);
      chk("down idx0", int'(o_idx[0]), 1);
      tick();
      chk("down idx1", int'(o_idx[0]), 0);
      hold_d    = o_data[0];
      hold_i    = o_idx[0];
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         in_flat[3:0] = ~in_flat[3:0];
         chk("stall data", int'(o_data[0]), int'(hold_d));
         chk("stall idx", int'(o_idx[0]), int'(hold_i));
         chk("stall valid", int'(o_valid[0]), 1);
      end
      out_ready = 1'b1;
      tick();
      chk("down idx2", int'(o_idx[0]), 15);
      chk("down last", int'(o_last[0]), 1);
      tick();
      chk("down done valid", int'(o_valid[0]), 0);
      chk("down done busy", int'(o_busy[0]), 0);

      // 5: len=0 up from 12; 10-ch build starts out of range
      send(2'b01, 4'd12, 5'd0);
      chk("oor data n10", int'(o_data[1]), 0);
      chk("oor idx n10", int'(o_idx[1]), 12);
      cnt  = '{0, 0};
      done = '{0, 0};
      for (int i = 0; i < 20; i++) begin
         for (int d = 0; d < 2; d++) begin
            if (o_valid[d] && !done[d]) begin
               if (d == 1 && cnt[1] == 1) chk("oor wrap n10", int'(o_idx[1]), 0);
               cnt[d]++;
               if (o_last[d]) done[d] = 1;
            end
         end
         tick();
      end
      chk("len0 beats n16", cnt[0], 16);
      chk("len0 beats n10", cnt[1], 10);

      // 6: reset in the middle of a len=8 burst
      send(2'b01, 4'd3, 5'd8);
      tick();
      chk("pre-rst idx", int'(o_idx[0]), 4);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-rst valid", int'(o_valid[0]), 0);
      chk("mid-rst busy", int'(o_busy[0]), 0);
      chk("mid-rst idx", int'(o_idx[0]), 0);
      chk("mid-rst valid n10", int'(o_valid[1]), 0);
      tick();
      tick();
      rst_n = 1'b1;
      in_flat[39:36] = 4'h6;
      tick();
      send(2'b00, 4'd9, 5'd0);
      chk("post-rst single data", int'(o_data[0]), 6);
      chk("post-rst single idx", int'(o_idx[0]), 9);
      chk("post-rst single last n10", int'(o_last[1]), 1);
      tick();
      chk("post-rst single busy", int'(o_busy[0]), 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
